// File: rtl/spi_master_core.sv
// spi_master_core: single-byte SPI master engine. The register file above it
// loads TX data, mode (CPOL/CPHA) and clock divider, then pulses start. This
// block generates SCLK/MOSI/CS_N, samples MISO and presents the received byte
// alongside a one-cycle done pulse.
//
// Optional feature macro: SPI_MASTER_LSB_FIRST_EN
//   defined     : adds input lsb_first_i, latched on an accepted start; when 1
//                 both shift-out and shift-in run LSB first.
//   not defined : no lsb_first_i port, transfers are always MSB first.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | cs_n high, sclk follows registered cpol input, waits for start
// S_SETUP | cs_n low, sclk at cpol for one half-period before first edge
// S_XFER  | 2*DATA_W half-periods, sclk toggles at each half-period end
// S_HOLD  | cs_n low, sclk back at cpol, mosi held for one half-period
// S_DONE  | cs_n high, done pulse, rx_data already valid

module spi_master_core #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              cpol_i,
    input  logic              cpha_i,
    input  logic [DIV_W-1:0]  clk_div_i,
    input  logic              miso_i,
`ifdef SPI_MASTER_LSB_FIRST_EN
    input  logic              lsb_first_i,
`endif
    output logic              sclk_o,
    output logic              mosi_o,
    output logic              cs_n_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] rx_data_o
);

    localparam int EDGE_W = $clog2(2 * DATA_W);
    localparam int BIT_W  = EDGE_W - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_XFER,
        S_HOLD,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic [EDGE_W-1:0]   edge_q, edge_d;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic [DATA_W-1:0]   rx_sr_q, rx_sr_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                cpol_q, cpol_d;
    logic                cpha_q, cpha_d;
    logic                lsb_q, lsb_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;

    logic                lsb_first_in;
    logic                half_end;
    logic                leading;
    logic                last_edge;
    logic                sample_now;
    logic [BIT_W-1:0]    cur_bit;

`ifdef SPI_MASTER_LSB_FIRST_EN
    assign lsb_first_in = lsb_first_i;
`else
    assign lsb_first_in = 1'b0;
`endif

    // Half-period ends when the counter reaches clk_div, giving clk_div+1 cycles.
    assign half_end   = (cnt_q == div_q);
    // Even edge numbers move sclk away from cpol (leading), odd ones return.
    assign leading    = ~edge_q[0];
    assign last_edge  = (edge_q == EDGE_W'(2 * DATA_W - 1));
    // CPHA=0 samples on leading edges, CPHA=1 on trailing edges.
    assign sample_now = leading ^ cpha_q;
    assign cur_bit    = edge_q[EDGE_W-1:1];

    function automatic logic [BIT_W-1:0] bit_pos(input logic [BIT_W-1:0] n,
                                                 input logic             lsb);
        bit_pos = lsb ? n : (BIT_W'(DATA_W - 1) - n);
    endfunction

    // Next-state and datapath decode; every _d defaults to its _q.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        edge_d    = edge_q;
        tx_d      = tx_q;
        rx_sr_d   = rx_sr_q;
        rx_data_d = rx_data_q;
        div_d     = div_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        lsb_d     = lsb_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;

        case (state_q)
            S_IDLE: begin
                sclk_d = cpol_i;
                cnt_d  = '0;
                edge_d = '0;
                if (start_i) begin
                    tx_d    = tx_data_i;
                    cpol_d  = cpol_i;
                    cpha_d  = cpha_i;
                    div_d   = clk_div_i;
                    lsb_d   = lsb_first_in;
                    rx_sr_d = '0;
                    // CPHA=0 needs the first bit valid before the first edge.
                    if (!cpha_i) begin
                        mosi_d = tx_data_i[bit_pos('0, lsb_first_in)];
                    end
                    state_d = S_SETUP;
                end
            end

            S_SETUP: begin
                sclk_d = cpol_q;
                if (half_end) begin
                    cnt_d   = '0;
                    state_d = S_XFER;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end

            S_XFER: begin
                if (half_end) begin
                    cnt_d  = '0;
                    sclk_d = ~sclk_q;
                    edge_d = edge_q + EDGE_W'(1);
                    if (sample_now) begin
                        if (lsb_q) begin
                            rx_sr_d = {miso_i, rx_sr_q[DATA_W-1:1]};
                        end else begin
                            rx_sr_d = {rx_sr_q[DATA_W-2:0], miso_i};
                        end
                    end else if (cpha_q) begin
                        mosi_d = tx_q[bit_pos(cur_bit, lsb_q)];
                    end else if (!last_edge) begin
                        mosi_d = tx_q[bit_pos(cur_bit + BIT_W'(1), lsb_q)];
                    end
                    if (last_edge) begin
                        edge_d  = '0;
                        state_d = S_HOLD;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end

            S_HOLD: begin
                sclk_d = cpol_q;
                if (half_end) begin
                    cnt_d = '0;
                    // Load here so rx_data is already valid while done is high.
                    rx_data_d = rx_sr_q;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            edge_q    <= '0;
            tx_q      <= '0;
            rx_sr_q   <= '0;
            rx_data_q <= '0;
            div_q     <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            lsb_q     <= 1'b0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            edge_q    <= edge_d;
            tx_q      <= tx_d;
            rx_sr_q   <= rx_sr_d;
            rx_data_q <= rx_data_d;
            div_q     <= div_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            lsb_q     <= lsb_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
        end
    end

    assign sclk_o    = sclk_q;
    assign mosi_o    = mosi_q;
    assign cs_n_o    = ~((state_q == S_SETUP) || (state_q == S_XFER) || (state_q == S_HOLD));
    assign busy_o    = (state_q != S_IDLE);
    assign done_o    = (state_q == S_DONE);
    assign rx_data_o = rx_data_q;

endmodule

// File: tb/tb_spi_master_core.sv
// Directed and randomized bench for spi_master_core. A protocol-level SPI
// slave reacts to sclk edges, and expected latency/data come from the
// transfer-level rules (H = clk_div+1, done at 1+(2*8+2)*H).

module tb_spi_master_core;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] tx_data;
    logic       cpol;
    logic       cpha;
    logic [7:0] clk_div;
    logic       miso;
    logic       lsb_first_v;
    logic       sclk;
    logic       mosi;
    logic       cs_n;
    logic       busy;
    logic       done;
    logic [7:0] rx_data;

    int n_tests = 0;
    int n_fail  = 0;

    // slave model state
    logic       m_pol = 1'b0;
    logic       m_pha = 1'b0;
    logic [7:0] m_sbyte = 8'h00;
    logic       loopback = 1'b0;
    logic       slave_miso = 1'b0;
    logic       prev_cs = 1'b1;
    logic       prev_sclk = 1'b0;
    logic [7:0] s_cap = 8'h00;
    logic       s_first = 1'b0;
    int         s_ncap = 0;
    int         s_idx = 0;
    int         rise_cnt = 0;

    always #5 clk = ~clk;

    assign miso = loopback ? mosi : slave_miso;

    spi_master_core #(.DATA_W(8), .DIV_W(8)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .start_i     (start),
        .tx_data_i   (tx_data),
        .cpol_i      (cpol),
        .cpha_i      (cpha),
        .clk_div_i   (clk_div),
        .miso_i      (miso),
`ifdef SPI_MASTER_LSB_FIRST_EN
        .lsb_first_i (lsb_first_v),
`endif
        .sclk_o      (sclk),
        .mosi_o      (mosi),
        .cs_n_o      (cs_n),
        .busy_o      (busy),
        .done_o      (done),
        .rx_data_o   (rx_data)
    );

    // Behavioural SPI slave: MSB-first, samples and drives on the edges
    // dictated by CPOL/CPHA.
    always @(negedge clk) begin
        if (cs_n === 1'b0 && prev_cs === 1'b1) begin
            s_idx    = 0;
            s_cap    = 8'h00;
            s_ncap   = 0;
            rise_cnt = 0;
            if (!m_pha) begin
                slave_miso = m_sbyte[7];
                s_idx      = 1;
            end
        end else if (cs_n === 1'b0 && sclk !== prev_sclk) begin
            if (sclk === 1'b1) rise_cnt++;
            if ((sclk !== m_pol) ^ m_pha) begin
                s_cap = {s_cap[6:0], mosi};
                if (s_ncap == 0) s_first = mosi;
                s_ncap++;
            end else if (s_idx < 8) begin
                slave_miso = m_sbyte[7 - s_idx];
                s_idx++;
            end
        end
        prev_cs   = cs_n;
        prev_sclk = sclk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before 500000 ns");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_xfer(input string tag, input logic [7:0] tx, input logic pol,
                            input logic pha, input logic [7:0] dv, input logic [7:0] sb,
                            input logic lb, input logic lsb, input logic scramble);
        int         h;
        int         exp_done;
        int         c;
        int         lo_cnt;
        int         busy_bad;
        logic       seen;
        logic [7:0] exp_rx;
        logic [7:0] exp_cap;
        logic       exp_first;
        h         = int'(dv) + 1;
        exp_done  = 1 + (2 * 8 + 2) * h;
        exp_rx    = lb ? tx : (lsb ? rev8(sb) : sb);
        exp_cap   = lsb ? rev8(tx) : tx;
        exp_first = lsb ? tx[0] : tx[7];
        m_pol     = pol;
        m_pha     = pha;
        m_sbyte   = sb;
        loopback  = lb;
        cpol      = pol;
        @(negedge clk);
        tx_data     = tx;
        cpha        = pha;
        clk_div     = dv;
        lsb_first_v = lsb;
        start       = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        c        = 1;
        seen     = 1'b0;
        lo_cnt   = 0;
        busy_bad = 0;
        while (!seen && c <= exp_done + 8) begin
            if (cs_n === 1'b0) lo_cnt++;
            if (busy !== 1'b1) busy_bad++;
            if (done === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (scramble) begin
                    tx_data     = 8'($urandom);
                    cpol        = 1'($urandom);
                    cpha        = 1'($urandom);
                    clk_div     = 8'($urandom);
                    lsb_first_v = 1'($urandom);
                end
                @(negedge clk);
                c++;
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'(1));
        check({tag, "_done_cycle"}, 32'(c), 32'(exp_done));
        check({tag, "_cs_low_cycles"}, 32'(lo_cnt), 32'(exp_done - 1));
        check({tag, "_busy_gaps"}, 32'(busy_bad), 32'(0));
        check({tag, "_rx_data"}, 32'(rx_data), 32'(exp_rx));
        check({tag, "_mosi_bits"}, 32'(s_cap), 32'(exp_cap));
        check({tag, "_mosi_first"}, 32'(s_first), 32'(exp_first));
        check({tag, "_sclk_rises"}, 32'(rise_cnt), 32'(8));
        check({tag, "_sclk_at_done"}, 32'(sclk), 32'(pol));
        cpol        = pol;
        cpha        = pha;
        tx_data     = tx;
        clk_div     = dv;
        lsb_first_v = lsb;
        if (!seen) do_reset();
    endtask

    initial begin
        int         c;
        int         dcount;
        logic [7:0] r_tx;
        logic [7:0] r_sb;
        logic [7:0] r_dv;
        logic       r_pol;
        logic       r_pha;
        logic       r_lsb;

        reset       = 1'b1;
        start       = 1'b0;
        tx_data     = 8'h00;
        cpol        = 1'b0;
        cpha        = 1'b0;
        clk_div     = 8'h00;
        lsb_first_v = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sclk", 32'(sclk), 32'(0));
        check("rst_mosi", 32'(mosi), 32'(0));
        check("rst_cs_n", 32'(cs_n), 32'(1));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_rx", 32'(rx_data), 32'(0));
        reset = 1'b0;
        @(negedge clk);

        // reset in cycle 10 of a mode-0 transfer
        loopback = 1'b1;
        m_pol    = 1'b0;
        m_pha    = 1'b0;
        tx_data  = 8'hA5;
        start    = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        check("t5_cs_n", 32'(cs_n), 32'(1));
        check("t5_sclk", 32'(sclk), 32'(0));
        check("t5_busy", 32'(busy), 32'(0));
        check("t5_rx", 32'(rx_data), 32'(0));
        reset  = 1'b0;
        dcount = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done === 1'b1) dcount++;
        end
        check("t5_no_done", 32'(dcount), 32'(0));
        check("t5_rx_after", 32'(rx_data), 32'(0));

        // mode 0, clk_div 0, loopback
        run_xfer("t1", 8'hA5, 1'b0, 1'b0, 8'd0, 8'h00, 1'b1, 1'b0, 1'b0);

        // mode 3, clk_div 3, slave returns 0xC3; sclk idles high afterwards
        run_xfer("t2", 8'h3C, 1'b1, 1'b1, 8'd3, 8'hC3, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("t2_sclk_idle", 32'(sclk), 32'(1));

        // modes 1 and 2
        run_xfer("t3m1", 8'h81, 1'b0, 1'b1, 8'd1, 8'h7E, 1'b0, 1'b0, 1'b0);
        run_xfer("t3m2", 8'h81, 1'b1, 1'b0, 8'd2, 8'h7E, 1'b0, 1'b0, 1'b0);

        // start re-pulsed in cycles 5 and 19 is ignored; cycle 20 accepted
        m_pol    = 1'b0;
        m_pha    = 1'b0;
        loopback = 1'b1;
        cpol     = 1'b0;
        @(negedge clk);
        tx_data = 8'hA5;
        cpha    = 1'b0;
        clk_div = 8'd0;
        start   = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 5) begin
                start   = 1'b1;
                tx_data = 8'h3F;
                clk_div = 8'd5;
            end
            if (k == 19) begin
                check("t4_done_c19", 32'(done), 32'(1));
                check("t4_rx_first", 32'(rx_data), 32'hA5);
                start   = 1'b1;
                tx_data = 8'h00;
                clk_div = 8'd0;
            end
            if (k == 20) begin
                check("t4_idle_c20", 32'(busy), 32'(0));
                start   = 1'b1;
                tx_data = 8'h55;
            end
        end
        @(negedge clk);
        start = 1'b0;
        c     = 1;
        check("t4_busy_c21", 32'(busy), 32'(1));
        while (done !== 1'b1 && c < 40) begin
            @(negedge clk);
            c++;
        end
        check("t4_done2_cycle", 32'(c), 32'(19));
        check("t4_rx_second", 32'(rx_data), 32'h55);
        @(negedge clk);

`ifdef SPI_MASTER_LSB_FIRST_EN
        run_xfer("t6lsb", 8'h01, 1'b0, 1'b0, 8'd0, 8'h00, 1'b1, 1'b1, 1'b0);
        run_xfer("t6msb", 8'h01, 1'b0, 1'b0, 8'd0, 8'h00, 1'b1, 1'b0, 1'b0);
`endif

        // randomized transfers with inputs scrambled while busy
        for (int n = 0; n < 12; n++) begin
            r_tx  = 8'($urandom);
            r_sb  = 8'($urandom);
            r_dv  = 8'($urandom_range(0, 4));
            r_pol = 1'($urandom);
            r_pha = 1'($urandom);
            r_lsb = 1'b0;
`ifdef SPI_MASTER_LSB_FIRST_EN
            r_lsb = 1'($urandom);
`endif
            run_xfer($sformatf("rnd%0d", n), r_tx, r_pol, r_pha, r_dv, r_sb,
                     1'($urandom), r_lsb, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
